field_draw_scheduler: RTL and testbench



---
 rtl/fluid_pkg.sv | 34 +++
 rtl/fb_clear.sv | 46 ++++
 rtl/field_draw_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_field_draw_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fluid_pkg.sv
// ============================================================================
//  Module      : fluid_pkg
//  Description : Shared Q16.16 types, field word layout and scheduler states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fluid_pkg;

    localparam int FRAC_BITS = 16;

    typedef logic [31:0] fix_t;

    // Field RAM word: xn occupies the most significant 32 bits.
    typedef struct packed {
        fix_t xn;
        fix_t yn;
        fix_t mag;
    } field_word_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_FETCH    = 3'd2,
        ST_WAIT_RD  = 3'd3,
        ST_LAUNCH   = 3'd4,
        ST_WAIT_BLK = 3'd5,
        ST_NEXT     = 3'd6,
        ST_DONE     = 3'd7
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/fb_clear.sv
// ============================================================================
//  Module      : fb_clear
//  Description : Frame-buffer clear address generator, one address per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_clear #(
    parameter int SIZE  = 307200,
    parameter int ADDRW = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    output logic [ADDRW-1:0] o_addr,
    output logic             o_we,
    output logic             o_last
);

    logic             r_active;
    logic [ADDRW-1:0] r_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_addr   <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_addr   <= '0;
        end else if (r_active) begin
            if (o_last) begin
                r_active <= 1'b0;
                r_addr   <= '0;
            end else begin
                r_addr <= r_addr + ADDRW'(1);
            end
        end
    end

    assign o_addr = r_addr;
    assign o_we   = r_active;
    assign o_last = r_active && (r_addr == ADDRW'(SIZE - 1));

endmodule

`default_nettype wire

// File: rtl/field_draw_scheduler.sv
// ============================================================================
//  Module      : field_draw_scheduler
//  Description : Walks the vector field, launches draw_block per cell and owns
//                the arbitrated frame-buffer write port (clear vs. draw_block).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module field_draw_scheduler
    import fluid_pkg::*;
#(
    parameter int DRAW_WIDTH       = 640,
    parameter int DRAW_HEIGHT      = 480,
    parameter int DRAW_SIZE        = DRAW_WIDTH * DRAW_HEIGHT,
    parameter int DRAW_ADDRW       = $clog2(DRAW_SIZE),
    parameter int DRAW_DATAW       = 1,
    parameter int FIELD_WIDTH      = 8,
    parameter int FIELD_HEIGHT     = 6,
    parameter int FIELD_SIZE       = FIELD_WIDTH * FIELD_HEIGHT,
    parameter int FIELD_ADDRW      = $clog2(FIELD_SIZE),
    parameter int FIELD_DATAW      = 96,
    parameter int BLOCK_SIZE       = DRAW_WIDTH / FIELD_WIDTH,
    parameter int FIELD_RD_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   clear_en,
    output logic                   busy,
    output logic                   done,
    output logic [FIELD_ADDRW-1:0] field_addr_read,
    input  logic [FIELD_DATAW-1:0] field_data_out,
    output logic                   blk_start,
    input  logic                   blk_done,
    output logic [31:0]            block_x,
    output logic [31:0]            block_y,
    output logic [31:0]            xn,
    output logic [31:0]            yn,
    output logic [31:0]            mag,
    input  logic [DRAW_ADDRW-1:0]  blk_addr_write,
    input  logic [DRAW_DATAW-1:0]  blk_data_in,
    input  logic                   blk_we,
    output logic [DRAW_ADDRW-1:0]  draw_addr_write,
    output logic [DRAW_DATAW-1:0]  draw_data_in,
    output logic                   draw_we
);

    localparam int COLW = (FIELD_WIDTH > 1) ? $clog2(FIELD_WIDTH) : 1;
    localparam int ROWW = (FIELD_HEIGHT > 1) ? $clog2(FIELD_HEIGHT) : 1;
    localparam int LATW = $clog2(FIELD_RD_LATENCY + 1);

    sched_state_t    r_state;
    logic [COLW-1:0] r_col;
    logic [ROWW-1:0] r_row;
    logic [LATW-1:0] r_rd_cnt;
    fix_t            r_xn;
    fix_t            r_yn;
    fix_t            r_mag;
    fix_t            r_block_x;
    fix_t            r_block_y;

    field_word_t     w_word;
    logic [15:0]     w_cx;
    logic [15:0]     w_cy;
    logic            w_last_col;
    logic            w_last_cell;
    logic            w_clr_start;
    logic            w_clr_we;
    logic            w_clr_last;
    logic [DRAW_ADDRW-1:0] w_clr_addr;

    assign w_word      = field_word_t'(field_data_out[$bits(field_word_t)-1:0]);
    assign w_cx        = 16'(int'(r_col) * BLOCK_SIZE + BLOCK_SIZE / 2);
    assign w_cy        = 16'(int'(r_row) * BLOCK_SIZE + BLOCK_SIZE / 2);
    assign w_last_col  = (r_col == COLW'(FIELD_WIDTH - 1));
    assign w_last_cell = w_last_col && (r_row == ROWW'(FIELD_HEIGHT - 1));
    assign w_clr_start = (r_state == ST_IDLE) && start && clear_en;

    fb_clear #(
        .SIZE  (DRAW_SIZE),
        .ADDRW (DRAW_ADDRW)
    ) u_fb_clear (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_clr_start),
        .o_addr  (w_clr_addr),
        .o_we    (w_clr_we),
        .o_last  (w_clr_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_rd_cnt  <= '0;
            r_xn      <= '0;
            r_yn      <= '0;
            r_mag     <= '0;
            r_block_x <= '0;
            r_block_y <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_col   <= '0;
                        r_row   <= '0;
                        r_state <= clear_en ? ST_CLEAR : ST_FETCH;
                    end
                end
                ST_CLEAR: begin
                    if (w_clr_last) r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    r_rd_cnt <= '0;
                    r_state  <= ST_WAIT_RD;
                end
                ST_WAIT_RD: begin
                    // Operands and coordinates stay frozen until the next cell's latch.
                    if (r_rd_cnt == LATW'(FIELD_RD_LATENCY - 1)) begin
                        r_xn      <= w_word.xn;
                        r_yn      <= w_word.yn;
                        r_mag     <= w_word.mag;
                        r_block_x <= fix_t'(w_cx) << FRAC_BITS;
                        r_block_y <= fix_t'(w_cy) << FRAC_BITS;
                        r_state   <= (w_word.mag == '0) ? ST_NEXT : ST_LAUNCH;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + LATW'(1);
                    end
                end
                ST_LAUNCH: begin
                    r_state <= ST_WAIT_BLK;
                end
                ST_WAIT_BLK: begin
                    if (blk_done) r_state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (w_last_cell) begin
                        r_state <= ST_DONE;
                    end else begin
                        if (w_last_col) begin
                            r_col <= '0;
                            r_row <= r_row + ROWW'(1);
                        end else begin
                            r_col <= r_col + COLW'(1);
                        end
                        r_state <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy            = (r_state != ST_IDLE);
    assign done            = (r_state == ST_DONE);
    assign blk_start       = (r_state == ST_LAUNCH);
    assign field_addr_read = FIELD_ADDRW'(int'(r_row) * FIELD_WIDTH + int'(r_col));
    assign block_x         = r_block_x;
    assign block_y         = r_block_y;
    assign xn              = r_xn;
    assign yn              = r_yn;
    assign mag             = r_mag;

    // Single frame-buffer write port; draw_block writes outside WAIT_BLK are dropped.
    always_comb begin
        draw_addr_write = '0;
        draw_data_in    = '0;
        draw_we         = 1'b0;
        if (r_state == ST_CLEAR) begin
            draw_addr_write = w_clr_addr;
            draw_we         = w_clr_we;
        end else if (r_state == ST_WAIT_BLK) begin
            draw_addr_write = blk_addr_write;
            draw_data_in    = blk_data_in;
            draw_we         = blk_we;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_field_draw_scheduler.sv
// ============================================================================
//  Module      : tb_field_draw_scheduler
//  Description : Directed self-checking bench for field_draw_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_field_draw_scheduler;

    localparam int CLR_N = 640 * 48;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [95:0] mem [48];

    // Instance A: latency 1, short frame buffer so a full clear stays cheap
    logic        a_start = 1'b0, a_clr = 1'b0;
    logic        a_busy, a_done, a_blk_start, a_blk_done;
    logic [5:0]  a_faddr;
    logic [95:0] a_rd;
    logic [31:0] a_bx, a_by, a_xn, a_yn, a_mag;
    logic [14:0] a_baddr, a_daddr;
    logic        a_bdata, a_ddata, a_bwe, a_dwe;

    // Instance B: latency 2, tiny frame buffer
    logic        b_start = 1'b0;
    logic        b_busy, b_done, b_blk_start, b_blk_done;
    logic [5:0]  b_faddr;
    logic [95:0] b_rd1, b_rd2;
    logic [31:0] b_bx, b_by, b_xn, b_yn, b_mag;
    logic [7:0]  b_baddr, b_daddr;
    logic        b_bdata, b_ddata, b_bwe, b_dwe;

    logic inj_done = 1'b0, inj_we = 1'b0, log_clr = 1'b0;

    field_draw_scheduler #(.DRAW_WIDTH(640), .DRAW_HEIGHT(48), .FIELD_RD_LATENCY(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .clear_en(a_clr), .busy(a_busy), .done(a_done),
        .field_addr_read(a_faddr), .field_data_out(a_rd), .blk_start(a_blk_start), .blk_done(a_blk_done),
        .block_x(a_bx), .block_y(a_by), .xn(a_xn), .yn(a_yn), .mag(a_mag),
        .blk_addr_write(a_baddr), .blk_data_in(a_bdata), .blk_we(a_bwe),
        .draw_addr_write(a_daddr), .draw_data_in(a_ddata), .draw_we(a_dwe));

    field_draw_scheduler #(.DRAW_WIDTH(16), .DRAW_HEIGHT(12), .FIELD_RD_LATENCY(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .clear_en(1'b0), .busy(b_busy), .done(b_done),
        .field_addr_read(b_faddr), .field_data_out(b_rd2), .blk_start(b_blk_start), .blk_done(b_blk_done),
        .block_x(b_bx), .block_y(b_by), .xn(b_xn), .yn(b_yn), .mag(b_mag),
        .blk_addr_write(b_baddr), .blk_data_in(b_bdata), .blk_we(b_bwe),
        .draw_addr_write(b_daddr), .draw_data_in(b_ddata), .draw_we(b_dwe));

    always @(posedge clk) begin
        a_rd  <= mem[a_faddr];
        b_rd1 <= mem[b_faddr];
        b_rd2 <= b_rd1;
    end

    // draw_block models: done pulse arrives 3 cycles after launch, writing meanwhile
    int   a_mcnt = 0, b_mcnt = 0;
    logic a_mdone = 1'b0, b_mdone = 1'b0;
    always @(negedge clk) begin
        a_mdone <= 1'b0;
        b_mdone <= 1'b0;
        if (a_blk_start) a_mcnt <= 3;
        else if (a_mcnt != 0) begin a_mcnt <= a_mcnt - 1; if (a_mcnt == 1) a_mdone <= 1'b1; end
        if (b_blk_start) b_mcnt <= 3;
        else if (b_mcnt != 0) begin b_mcnt <= b_mcnt - 1; if (b_mcnt == 1) b_mdone <= 1'b1; end
    end
    assign a_blk_done = a_mdone | inj_done;
    assign a_bwe      = (a_mcnt != 0) | inj_we;
    assign a_baddr    = 15'd100 + 15'(a_mcnt);
    assign a_bdata    = 1'b1;
    assign b_blk_done = b_mdone;
    assign b_bwe      = (b_mcnt != 0);
    assign b_baddr    = 8'd100 + 8'(b_mcnt);
    assign b_bdata    = 1'b1;

    // Launch logs
    int          a_n = 0, b_n = 0, a_wes = 0, b_wes = 0;
    logic [31:0] a_lbx [64], a_lby [64], a_lxn [64], a_lyn [64], a_lmg [64];
    logic [31:0] b_lbx [64], b_lby [64], b_lxn [64], b_lyn [64], b_lmg [64];
    int          a_lt [64], b_lt [64];
    always @(negedge clk) begin
        if (log_clr) begin
            a_n <= 0; b_n <= 0; a_wes <= 0; b_wes <= 0;
        end else begin
            if (a_blk_start && a_n < 64) begin
                a_lbx[a_n] <= a_bx; a_lby[a_n] <= a_by; a_lxn[a_n] <= a_xn;
                a_lyn[a_n] <= a_yn; a_lmg[a_n] <= a_mag; a_lt[a_n] <= cyc; a_n <= a_n + 1;
            end
            if (b_blk_start && b_n < 64) begin
                b_lbx[b_n] <= b_bx; b_lby[b_n] <= b_by; b_lxn[b_n] <= b_xn;
                b_lyn[b_n] <= b_yn; b_lmg[b_n] <= b_mag; b_lt[b_n] <= cyc; b_n <= b_n + 1;
            end
            if (a_dwe && a_ddata) a_wes <= a_wes + 1;
            if (b_dwe && b_ddata) b_wes <= b_wes + 1;
        end
    end

    typedef struct {
        int          inst;
        int          k;
        logic [31:0] bx, by, xn, yn, mg;
    } vec_t;
    vec_t vt [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic fill(input int z0, input int z1);
        for (int i = 0; i < 48; i++)
            mem[i] = {32'(i) << 16, (32'(i) << 16) | 32'h8000,
                      (i == z0 || i == z1) ? 32'h0 : 32'h0014_0000};
    endtask

    task automatic clr_log();
        log_clr = 1'b1;
        @(negedge clk);
        log_clr = 1'b0;
    endtask

    task automatic check_table(input int inst);
        for (int i = 0; i < 9; i++) begin
            if (vt[i].inst == inst) begin
                if (inst == 3) begin
                    chk($sformatf("b_bx[%0d]", vt[i].k), b_lbx[vt[i].k], vt[i].bx);
                    chk($sformatf("b_by[%0d]", vt[i].k), b_lby[vt[i].k], vt[i].by);
                    chk($sformatf("b_xn[%0d]", vt[i].k), b_lxn[vt[i].k], vt[i].xn);
                    chk($sformatf("b_yn[%0d]", vt[i].k), b_lyn[vt[i].k], vt[i].yn);
                    chk($sformatf("b_mag[%0d]", vt[i].k), b_lmg[vt[i].k], vt[i].mg);
                end else begin
                    chk($sformatf("a%0d_bx[%0d]", inst, vt[i].k), a_lbx[vt[i].k], vt[i].bx);
                    chk($sformatf("a%0d_by[%0d]", inst, vt[i].k), a_lby[vt[i].k], vt[i].by);
                    chk($sformatf("a%0d_xn[%0d]", inst, vt[i].k), a_lxn[vt[i].k], vt[i].xn);
                    chk($sformatf("a%0d_yn[%0d]", inst, vt[i].k), a_lyn[vt[i].k], vt[i].yn);
                    chk($sformatf("a%0d_mag[%0d]", inst, vt[i].k), a_lmg[vt[i].k], vt[i].mg);
                end
            end
        end
    endtask

    // Pulse start at the current negedge; returns at the negedge of cycle 1.
    task automatic start_a(input logic clr);
        a_start = 1'b1;
        a_clr   = clr;
        @(negedge clk);
        a_start = 1'b0;
        a_clr   = 1'b0;
    endtask

    // Waits for done; n is the cycle index (start-sampling edge = cycle 0) of DONE.
    task automatic wait_done_a(input int n0, input int budget, input bit inj, output int n);
        int prev;
        bit did;
        prev = -1;
        did  = 1'b0;
        n    = n0;
        while (a_done !== 1'b1 && n < budget) begin
            inj_done = inj && (int'(a_faddr) != prev);
            prev     = int'(a_faddr);
            if (inj && !did && a_n == 20) begin
                a_start = 1'b1; a_clr = 1'b1; did = 1'b1;
            end else begin
                a_start = 1'b0; a_clr = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        inj_done = 1'b0;
        a_start  = 1'b0;
        a_clr    = 1'b0;
        if (a_done !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL a_done_timeout: got no done within %0d cycles, expected done", budget);
        end
    endtask

    task automatic post_done_a(input string tag);
        @(negedge clk);
        chk({tag, "_done_width"}, 32'(a_done), 32'd0);
        chk({tag, "_busy_after"}, 32'(a_busy), 32'd0);
    endtask

    initial begin
        int n, errs, guard;

        vt[0] = '{1,  0, 32'h0028_0000, 32'h0028_0000, 32'h0000_0000, 32'h0000_8000, 32'h0014_0000};
        vt[1] = '{1,  9, 32'h0078_0000, 32'h0078_0000, 32'h0009_0000, 32'h0009_8000, 32'h0014_0000};
        vt[2] = '{1, 20, 32'h0168_0000, 32'h00C8_0000, 32'h0014_0000, 32'h0014_8000, 32'h0014_0000};
        vt[3] = '{1, 47, 32'h0258_0000, 32'h01B8_0000, 32'h002F_0000, 32'h002F_8000, 32'h0014_0000};
        vt[4] = '{2,  2, 32'h00C8_0000, 32'h0028_0000, 32'h0002_0000, 32'h0002_8000, 32'h0014_0000};
        vt[5] = '{2,  3, 32'h0168_0000, 32'h0028_0000, 32'h0004_0000, 32'h0004_8000, 32'h0014_0000};
        vt[6] = '{2, 45, 32'h0208_0000, 32'h01B8_0000, 32'h002E_0000, 32'h002E_8000, 32'h0014_0000};
        vt[7] = '{3,  5, 32'h000B_0000, 32'h0001_0000, 32'h0005_0000, 32'h0005_8000, 32'h0014_0000};
        vt[8] = '{3, 47, 32'h000F_0000, 32'h000B_0000, 32'h002F_0000, 32'h002F_8000, 32'h0014_0000};

        fill(-1, -1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_blk_start", 32'(a_blk_start), 0);
        chk("rst_draw_we", 32'(a_dwe), 0);
        chk("rst_draw_addr", 32'(a_daddr), 0);
        chk("rst_field_addr", 32'(a_faddr), 0);
        chk("rst_block_x", a_bx, 0);
        chk("rst_block_y", a_by, 0);
        chk("rst_mag", a_mag, 0);
        rst = 1'b0;
        @(negedge clk);

        // Frame 1: no clear, every cell drawn; 48 cells x 7 cycles, DONE at 337
        clr_log();
        start_a(1'b0);
        chk("f1_busy_c1", 32'(a_busy), 1);
        wait_done_a(1, 2000, 1'b0, n);
        chk("f1_done_cycle", n, 337);
        post_done_a("f1");
        chk("f1_launches", a_n, 48);
        chk("f1_blk_writes", a_wes, 144);
        chk("f1_cell_period", a_lt[1] - a_lt[0], 7);
        check_table(1);

        // Frame 2: clear first, blk_we forced high during the clear
        clr_log();
        inj_we = 1'b1;
        start_a(1'b1);
        chk("clr_busy_c1", 32'(a_busy), 1);
        errs = 0;
        for (int i = 0; i < CLR_N; i++) begin
            if (!(a_dwe === 1'b1 && a_daddr === 15'(i) && a_ddata === 1'b0)) begin
                if (errs == 0)
                    $display("FAIL clear_write[%0d]: got we=%b addr=%0d data=%b, expected we=1 addr=%0d data=0",
                             i, a_dwe, a_daddr, a_ddata, i);
                errs++;
            end
            @(negedge clk);
        end
        chk("clear_bad_writes", errs, 0);
        chk("clear_end_we", 32'(a_dwe), 0);
        inj_we = 1'b0;
        wait_done_a(CLR_N + 1, CLR_N + 2000, 1'b0, n);
        chk("clr_done_cycle", n, CLR_N + 337);
        post_done_a("clr");
        chk("clr_launches", a_n, 48);

        // Frame 3: mag=0 at cells 3 and 47 (skipped cells cost 3 cycles)
        fill(3, 47);
        clr_log();
        start_a(1'b0);
        wait_done_a(1, 2000, 1'b0, n);
        chk("skip_done_cycle", n, 329);
        post_done_a("skip");
        chk("skip_launches", a_n, 46);
        chk("skip_blk_writes", a_wes, 138);
        chk("skip_gap", a_lt[3] - a_lt[2], 10);
        check_table(2);

        // Frame 4: stray start mid-frame and blk_done pulses during FETCH/WAIT_RD
        fill(-1, -1);
        clr_log();
        start_a(1'b0);
        wait_done_a(1, 2000, 1'b1, n);
        chk("inj_done_cycle", n, 337);
        post_done_a("inj");
        chk("inj_launches", a_n, 48);
        chk("inj_blk_writes", a_wes, 144);

        // Frame 5: reset while cell 10 is in WAIT_BLK
        clr_log();
        start_a(1'b0);
        guard = 0;
        while (!(a_blk_start === 1'b1 && a_n == 10) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_mid_reach_cell10", 32'(guard < 2000), 1);
        @(negedge clk);
        chk("rst_mid_pass_we", 32'(a_dwe), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 32'(a_busy), 0);
        chk("rst_mid_draw_we", 32'(a_dwe), 0);
        chk("rst_mid_blk_we_live", 32'(a_bwe), 1);
        chk("rst_mid_field_addr", 32'(a_faddr), 0);
        chk("rst_mid_block_x", a_bx, 0);
        chk("rst_mid_xn", a_xn, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_mid_idle_busy", 32'(a_busy), 0);
        clr_log();
        start_a(1'b0);
        wait_done_a(1, 2000, 1'b0, n);
        chk("restart_done_cycle", n, 337);
        post_done_a("restart");
        chk("restart_launches", a_n, 48);
        chk("restart_first_bx", a_lbx[0], 32'h0028_0000);
        chk("restart_first_xn", a_lxn[0], 32'h0);

        // Instance B: read latency 2, 8 cycles per drawn cell, DONE at 385
        clr_log();
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        n = 1;
        while (b_done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("b_done_cycle", n, 385);
        @(negedge clk);
        chk("b_busy_after", 32'(b_busy), 0);
        chk("b_launches", b_n, 48);
        chk("b_cell_period", b_lt[1] - b_lt[0], 8);
        chk("b_blk_writes", b_wes, 144);
        check_table(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
